// File: rtl/tpu_pkg.sv
// tpu_pkg: shared types and defaults for the tpumac array and its A/B feeders.
package tpu_pkg;
  localparam int BITS_AB = 8;
  localparam int DIM = 8;
  localparam int LAST_STEP = 2 * DIM - 2;
  typedef logic signed [BITS_AB-1:0] elem_t;
  typedef elem_t [DIM-1:0] row_t;
  typedef enum logic {IDLE, STREAM} state_t;
endpackage

// File: rtl/systolic_a_feeder.sv
// systolic_a_feeder: stores a DIM x DIM operand-A matrix and streams it diagonally skewed into the array.
module systolic_a_feeder #(
  parameter int BITS_AB = tpu_pkg::BITS_AB,
  parameter int DIM = tpu_pkg::DIM
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     WrEn,
  input  logic [$clog2(DIM)-1:0]   Arow,
  input  logic [DIM*BITS_AB-1:0]   Ain,
  input  logic                     start,
  output logic [DIM*BITS_AB-1:0]   Aout,
  output logic                     Aout_valid,
  output logic                     busy,
  output logic                     done
);
  import tpu_pkg::*;
  localparam int AW = $clog2(DIM);
  localparam int KW = $clog2(2 * DIM);
  localparam logic [KW-1:0] LAST_K = KW'(2 * DIM - 2);
  state_t state, state_nxt;
  logic [KW-1:0] k;
  logic [DIM-1:0][DIM-1:0][BITS_AB-1:0] mem;
  logic [DIM-1:0][BITS_AB-1:0] nxt;
  logic last;
  assign last = (state == STREAM) && en && (k == LAST_K);
  assign busy = (state == STREAM);
  // Lane i sees column k-i of its row; the unsigned difference wraps when k < i.
  for (genvar i = 0; i < DIM; i++) begin : g_lane
    logic [KW-1:0] d;
    assign d = k - KW'(i);
    assign nxt[i] = (k >= KW'(i) && d < KW'(DIM)) ? mem[i][d[AW-1:0]] : '0;
  end
  always_comb begin
    state_nxt = state;
    if (state == IDLE) state_nxt = start ? STREAM : IDLE;
    else state_nxt = last ? IDLE : STREAM;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
      k <= '0;
      Aout <= '0;
      Aout_valid <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= last;
      if (state == IDLE) begin
        if (WrEn && 32'(Arow) < DIM) mem[Arow] <= Ain;
        if (start) k <= '0;
        if (en) begin
          Aout <= '0;
          Aout_valid <= 1'b0;
        end
      end else if (en) begin
        Aout <= nxt;
        Aout_valid <= 1'b1;
        k <= last ? '0 : k + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_systolic_a_feeder.sv
// tb_systolic_a_feeder: directed checks of load, skewed streaming, stalls, writes and reset for DIM=4.
module tb_systolic_a_feeder;
  logic clk, rst_n, en, WrEn, start;
  logic [1:0] Arow;
  logic [31:0] Ain, Aout;
  logic Aout_valid, busy, done;
  logic [7:0] mat [4][4];
  logic [31:0] first_col;
  int checks, errors;

  systolic_a_feeder #(.BITS_AB(8), .DIM(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .WrEn(WrEn), .Arow(Arow), .Ain(Ain),
    .start(start), .Aout(Aout), .Aout_valid(Aout_valid), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_col(input int s);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)
      if (s - i >= 0 && s - i < 4) r[i*8 +: 8] = mat[i][s-i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_run(input int stall_at, input int wr_at, input bit hand);
    int vcnt, dcnt;
    vcnt = 0;
    dcnt = 0;
    start = 1'b1;
    en = 1'b1;
    tick();
    start = 1'b0;
    chk("enter_busy", 32'(busy), 32'd1);
    chk("enter_valid", 32'(Aout_valid), 32'd0);
    for (int s = 0; s < 7; s++) begin
      tick();
      if (s == 0) first_col = Aout;
      chk($sformatf("col_s%0d", s), Aout, exp_col(s));
      chk($sformatf("busy_s%0d", s), 32'(busy), 32'(s < 6));
      if (Aout_valid) vcnt++;
      if (done) dcnt++;
      if (hand && s == 0) chk("hand_s0", Aout, 32'h00000000);
      if (hand && s == 2) chk("hand_s2", Aout, 32'h00201102);
      if (hand && s == 3) chk("hand_s3", Aout, 32'h30211203);
      if (hand && s == 6) chk("hand_s6", Aout, 32'h33000000);
      if (s == wr_at) begin
        WrEn = 1'b1;
        Arow = 2'd1;
        Ain = 32'h7F7F7F7F;
      end else WrEn = 1'b0;
      if (s == stall_at) begin
        en = 1'b0;
        for (int t = 0; t < 3; t++) begin
          tick();
          chk("stall_col", Aout, exp_col(s));
          chk("stall_valid", 32'(Aout_valid), 32'd1);
          chk("stall_busy", 32'(busy), 32'd1);
          if (done) dcnt++;
        end
        en = 1'b1;
      end
    end
    WrEn = 1'b0;
    chk("valid_cycles", 32'(vcnt), 32'd7);
    chk("done_count", 32'(dcnt), 32'd1);
    chk("done_last", 32'(done), 32'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    en = 1'b0;
    WrEn = 1'b0;
    start = 1'b0;
    Arow = '0;
    Ain = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) mat[i][j] = 8'(16 * i + j);
    tick();
    tick();
    chk("rst_aout", Aout, 32'h0);
    chk("rst_valid", 32'(Aout_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    for (int r = 0; r < 4; r++) begin
      WrEn = 1'b1;
      Arow = 2'(r);
      Ain = {mat[r][3], mat[r][2], mat[r][1], mat[r][0]};
      tick();
    end
    WrEn = 1'b0;
    tick();
    chk("load_no_busy", 32'(busy), 32'd0);
    do_run(-1, -1, 1'b1);
    do_run(2, 1, 1'b1);
    do_run(-1, -1, 1'b1);
    en = 1'b0;
    tick();
    chk("idle_hold_aout", Aout, 32'h33000000);
    chk("idle_hold_valid", 32'(Aout_valid), 32'd1);
    chk("idle_done_clr", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    en = 1'b1;
    tick();
    chk("idle_en_aout", Aout, 32'h0);
    chk("idle_en_valid", 32'(Aout_valid), 32'd0);
    mat[0][0] = 8'h80;
    mat[0][1] = 8'h81;
    mat[0][2] = 8'h82;
    mat[0][3] = 8'h83;
    WrEn = 1'b1;
    Arow = 2'd0;
    Ain = 32'h83828180;
    do_run(-1, -1, 1'b0);
    chk("wr_start_lane0", first_col, 32'h00000080);
    chk("sign_kept", 32'($signed(first_col[7:0])), 32'hFFFFFF80);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int s = 0; s < 5; s++) tick();
    chk("pre_rst_col4", Aout, exp_col(4));
    rst_n = 1'b0;
    #1;
    chk("midrst_aout", Aout, 32'h0);
    chk("midrst_valid", 32'(Aout_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) mat[i][j] = 8'h00;
    do_run(-1, -1, 1'b0);
    tick();
    chk("final_busy", 32'(busy), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
